// File: rtl/dequant_zigzag.sv
// dequant_zigzag
// Dequantizes a stream of JPEG coefficients that arrive in zigzag order and
// hands them to an IDCT as row-major blocks. Two coefficient banks form a
// ping-pong buffer, so one block can be written while the other streams out.
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   qt_we       quant-table write strobe
//   qt_addr     quant-table index (row-major)
//   qt_data     unsigned quant step
//   coef_valid  input coefficient valid
//   coef_ready  write bank has room for a coefficient
//   coef_in     signed quantized coefficient, zigzag order
//   idct_start  one-cycle block-start pulse
//   F_out       signed dequantized coefficient, row-major order (0 when idle)
//   F_valid     F_out valid
//   idct_done   IDCT has consumed the current block
module dequant_zigzag #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              qt_we,
    input  logic [5:0]        qt_addr,
    input  logic [7:0]        qt_data,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_in,
    output logic              idct_start,
    output logic [OUT_W-1:0]  F_out,
    output logic              F_valid,
    input  logic              idct_done
);

    localparam int PW = COEF_W + 9;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] STREAM    = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    // Zigzag position k -> natural (row-major) index.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic [7:0]              qt_q [64];
    logic signed [OUT_W-1:0] bank_q [2][64];

    logic [1:0]       state_q, state_d;
    logic [5:0]       n_q, n_d;
    logic [5:0]       k_q, k_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic             start_q, start_d;
    logic             fvalid_q, fvalid_d;
    logic [OUT_W-1:0] fout_q, fout_d;

    logic                    accept;
    logic                    wrap;
    logic                    rd_release;
    logic [7:0]              qt_sel;
    logic signed [PW-1:0]    prod;
    logic signed [OUT_W-1:0] sat_val;

    assign coef_ready = ~full_q[wr_bank_q];
    assign idct_start = start_q;
    assign F_valid    = fvalid_q;
    assign F_out      = fout_q;

    // Write side: the quant step is looked up at the natural index of the
    // current zigzag slot. The table read sees the pre-write value when qt_we
    // hits the same entry, because the table is only updated at the edge.
    // The step is zero-extended so the multiply stays signed x unsigned.
    always_comb begin
        accept    = coef_valid & coef_ready;
        wrap      = accept & (k_q == 6'd63);
        qt_sel    = qt_q[ZZ[k_q]];
        prod      = $signed(coef_in) * $signed({1'b0, qt_sel});
        if (prod > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (prod < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_val = prod[OUT_W-1:0];
        end
        k_d       = accept ? k_q + 6'd1 : k_q;
        wr_bank_d = wrap ? ~wr_bank_q : wr_bank_q;
    end

    // Read FSM. Outputs are computed here and registered, so idct_start
    // appears the cycle after START and the stream follows it directly.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rd_bank_d  = rd_bank_q;
        start_d    = 1'b0;
        fvalid_d   = 1'b0;
        fout_d     = '0;
        rd_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                n_d     = 6'd0;
                state_d = STREAM;
            end
            STREAM: begin
                fvalid_d = 1'b1;
                fout_d   = bank_q[rd_bank_q][n_q];
                n_d      = n_q + 6'd1;
                if (n_q == 6'd63) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (idct_done) begin
                    rd_release = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full flags: a completed write and a release always target different
    // banks (a full bank blocks writes), so both can land in the same edge.
    always_comb begin
        full_d = full_q;
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wrap) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Control state and quant table; reset restores a unit quant table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= 6'd0;
            k_q       <= 6'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            start_q   <= 1'b0;
            fvalid_q  <= 1'b0;
            fout_q    <= '0;
            for (int i = 0; i < 64; i++) begin
                qt_q[i] <= 8'd1;
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            start_q   <= start_d;
            fvalid_q  <= fvalid_d;
            fout_q    <= fout_d;
            if (qt_we) begin
                qt_q[qt_addr] <= qt_data;
            end
        end
    end

    // Coefficient storage carries no reset: stale contents are unreachable
    // once the full flags are cleared.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            bank_q[wr_bank_q][ZZ[k_q]] <= sat_val;
        end
    end

endmodule

// File: tb/tb_dequant_zigzag.sv
// tb_dequant_zigzag
// Self-checking bench for dequant_zigzag: a scoreboard queue of expected
// row-major outputs is filled as each block is written, a negedge monitor
// pops and compares every F_valid cycle, and a spot table pins known values.
module tb_dequant_zigzag;

    logic        clk = 1'b0;
    logic        rst;
    logic        qt_we;
    logic [5:0]  qt_addr;
    logic [7:0]  qt_data;
    logic        coef_valid;
    logic        coef_ready;
    logic [11:0] coef_in;
    logic        idct_start;
    logic [15:0] F_out;
    logic        F_valid;
    logic        idct_done;

    dequant_zigzag #(.COEF_W(12), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .qt_we      (qt_we),
        .qt_addr    (qt_addr),
        .qt_data    (qt_data),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_in    (coef_in),
        .idct_start (idct_start),
        .F_out      (F_out),
        .F_valid    (F_valid),
        .idct_done  (idct_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int test;
        int n;
        int value;
    } spot_t;

    spot_t spots [11];
    int    zz [64];
    int    qtModel [64];
    int    blk [64];
    int    expQ [$];
    int    capQ [$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    startCount = 0;
    bit    prevStart  = 1'b0;
    int    monExp;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // Zigzag order built by walking anti-diagonals, alternating direction.
    function automatic void buildZz();
        int i = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[i] = r * 8 + (s - r);
                    i++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[i] = r * 8 + (s - r);
                    i++;
                end
            end
        end
    endfunction

    function automatic int sat16(input longint p);
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return int'(p);
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prevStart = 1'b0;
        end else begin
            if (prevStart) begin
                checkOutput("F_valid right after idct_start", int'(F_valid), 1);
                checkOutput("idct_start width", int'(idct_start), 0);
            end
            if (idct_start) begin
                startCount++;
            end
            if (F_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected F_valid", int'(F_valid), 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput($sformatf("F_out stream #%0d", capQ.size()), int'($signed(F_out)), monExp);
                end
                capQ.push_back(int'($signed(F_out)));
            end else begin
                checkOutput("F_out idle", int'($signed(F_out)), 0);
            end
            prevStart = idct_start;
        end
    end

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        for (int i = 0; i < 64; i++) qtModel[i] = 1;
    endtask

    task automatic writeQt(input int a, input int d);
        qt_we   = 1'b1;
        qt_addr = 6'(a);
        qt_data = 8'(d);
        @(negedge clk);
        qt_we   = 1'b0;
        qtModel[a] = d;
    endtask

    task automatic pulseDone();
        idct_done = 1'b1;
        @(negedge clk);
        idct_done = 1'b0;
    endtask

    // Drives one 64-coefficient block in zigzag order, honouring coef_ready,
    // then pushes the block's row-major expected values to the scoreboard.
    task automatic applyStimulus(input int coefs [64]);
        int expv [64];
        int k = 0;
        int waitCyc = 0;
        for (int j = 0; j < 64; j++) begin
            expv[zz[j]] = sat16(longint'(coefs[j]) * qtModel[zz[j]]);
        end
        while (k < 64) begin
            if (coef_ready) begin
                coef_valid = 1'b1;
                coef_in    = 12'(coefs[k]);
                @(negedge clk);
                k++;
                waitCyc = 0;
            end else begin
                coef_valid = 1'b0;
                @(negedge clk);
                waitCyc++;
                if (waitCyc > 400) begin
                    failNow("coef_ready wait");
                    break;
                end
            end
        end
        coef_valid = 1'b0;
        for (int j = 0; j < 64; j++) expQ.push_back(expv[j]);
    endtask

    task automatic waitOutputs(input int target, input string name);
        int cyc = 0;
        while (capQ.size() < target && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checkOutput(name, capQ.size(), target);
    endtask

    task automatic runSpots(input int test, input int base);
        for (int i = 0; i < 11; i++) begin
            if (spots[i].test == test) begin
                if (base + spots[i].n < capQ.size()) begin
                    checkOutput($sformatf("spot t%0d n=%0d", test, spots[i].n),
                                capQ[base + spots[i].n], spots[i].value);
                end else begin
                    failNow($sformatf("spot t%0d n=%0d missing", test, spots[i].n));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int s0;
        int c0;
        int cyc;

        spots = '{'{1, 0, 1}, '{1, 1, 2}, '{1, 8, 3}, '{1, 16, 4}, '{1, 9, 5}, '{1, 63, 64},
                  '{2, 0, 1600}, '{2, 1, 0}, '{2, 63, 0},
                  '{3, 0, 32767}, '{3, 1, -32768}};
        buildZz();
        rst        = 1'b1;
        qt_we      = 1'b0;
        qt_addr    = '0;
        qt_data    = '0;
        coef_valid = 1'b0;
        coef_in    = '0;
        idct_done  = 1'b0;
        @(negedge clk);
        doReset();

        $display("[TB] reset state");
        checkOutput("reset coef_ready", int'(coef_ready), 1);
        checkOutput("reset F_valid", int'(F_valid), 0);
        checkOutput("reset idct_start", int'(idct_start), 0);
        checkOutput("reset F_out", int'($signed(F_out)), 0);

        $display("[TB] unit table, ramp block");
        for (int k = 0; k < 64; k++) blk[k] = k + 1;
        base = capQ.size();
        applyStimulus(blk);
        checkOutput("idct_start one half-cycle after last accept", int'(idct_start), 0);
        @(negedge clk);
        checkOutput("idct_start one cycle after last accept", int'(idct_start), 0);
        @(negedge clk);
        checkOutput("idct_start two cycles after last accept", int'(idct_start), 1);
        waitOutputs(base + 64, "ramp block output count");
        runSpots(1, base);
        checkOutput("ramp block start pulses", startCount, 1);
        pulseDone();

        $display("[TB] qt=16, DC only");
        for (int a = 0; a < 64; a++) writeQt(a, 16);
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = 100;
        base = capQ.size();
        applyStimulus(blk);
        waitOutputs(base + 64, "DC block output count");
        runSpots(2, base);
        pulseDone();

        $display("[TB] saturation block, idct_done during stream");
        writeQt(0, 255);
        writeQt(1, 255);
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = 2047;
        blk[1] = -2048;
        blk[2] = -3;
        base = capQ.size();
        applyStimulus(blk);
        cyc = 0;
        while (capQ.size() < base + 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        pulseDone();
        waitOutputs(base + 64, "saturation block output count");
        runSpots(3, base);
        s0 = startCount;

        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(4095)) - 2048;
        base = capQ.size();
        applyStimulus(blk);
        repeat (10) @(negedge clk);
        checkOutput("early idct_done ignored (no restart)", startCount, s0);
        checkOutput("coef_ready with both banks full", int'(coef_ready), 0);
        pulseDone();
        checkOutput("coef_ready after release", int'(coef_ready), 1);
        waitOutputs(base + 64, "random block output count");
        pulseDone();

        $display("[TB] three blocks back-to-back");
        doReset();
        checkOutput("coef_ready after second reset", int'(coef_ready), 1);
        s0 = startCount;
        for (int k = 0; k < 64; k++) blk[k] = k + 1;
        base = capQ.size();
        applyStimulus(blk);
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(200)) - 100;
        applyStimulus(blk);
        checkOutput("coef_ready after 2nd block", int'(coef_ready), 0);
        waitOutputs(base + 64, "block 1 output count");
        runSpots(1, base);
        checkOutput("coef_ready while done withheld", int'(coef_ready), 0);
        pulseDone();
        checkOutput("coef_ready after single done", int'(coef_ready), 1);
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(4095)) - 2048;
        applyStimulus(blk);
        waitOutputs(base + 128, "block 2 output count");
        pulseDone();
        waitOutputs(base + 192, "block 3 output count");
        pulseDone();
        checkOutput("back-to-back start pulses", startCount - s0, 3);

        $display("[TB] reset mid-stream");
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(4095)) - 2048;
        base = capQ.size();
        applyStimulus(blk);
        cyc = 0;
        while (capQ.size() < base + 30 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-stream reset F_valid", int'(F_valid), 0);
        checkOutput("mid-stream reset idct_start", int'(idct_start), 0);
        checkOutput("mid-stream reset coef_ready", int'(coef_ready), 1);
        checkOutput("mid-stream reset F_out", int'($signed(F_out)), 0);
        rst = 1'b0;
        expQ.delete();
        for (int i = 0; i < 64; i++) qtModel[i] = 1;
        s0 = startCount;
        c0 = capQ.size();
        repeat (20) @(negedge clk);
        checkOutput("no start after reset", startCount, s0);
        checkOutput("no output after reset", capQ.size(), c0);
        for (int k = 0; k < 64; k++) blk[k] = k + 1;
        base = capQ.size();
        applyStimulus(blk);
        waitOutputs(base + 64, "post-reset block output count");
        runSpots(1, base);
        pulseDone();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
